// File: rtl/mips_multicycle_control.sv
// Main control FSM for a multi-cycle MIPS-32 datapath (shared ALU, unified
// instruction/data memory, register file). It decodes opcode/funct and drives
// every datapath select and strobe. Memory states wait on mem_ready.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   opcode, funct            IR[31:26] and IR[5:0], held stable outside FETCH
//   zero                     ALU zero flag; the datapath ANDs it with pc_write_cond
//   mem_ready                memory access completes this cycle
//   pc_write..pc_source      datapath control, Moore-decoded from state
//   state                    current state encoding
//   illegal                  sticky illegal opcode/funct flag
//   retired                  retired-instruction count, wraps modulo 2^CNT_W
module mips_multicycle_control #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_ctrl,
   output logic [1:0]       pc_source,
   output logic [3:0]       state,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EXEC = 4'd10,
      S_ADDI_WB   = 4'd11
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_e           state_q, state_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             retire_c;

   // The zero flag is consumed by the datapath PC-enable gate, not here.
   logic unused_zero;
   assign unused_zero = zero;

   // State, counter and sticky flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         retired_q <= retired_d;
      end
   end

   // Next-state and Moore output decode; memory strobes qualified by mem_ready.
   always_comb begin
      state_d       = state_q;
      illegal_d     = illegal_q;
      retire_c      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_ctrl      = 3'b000;
      pc_source     = 2'b00;

      unique case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            alu_ctrl  = ALU_ADD;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            // Branch target is precomputed here into ALUOut.
            alu_src_b = 2'b11;
            alu_ctrl  = ALU_ADD;
            case (opcode)
               OP_RTYPE:     state_d = S_R_EXEC;
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDI_EXEC;
               default: begin
                  state_d   = S_FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_ctrl  = ALU_ADD;
            state_d   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready) state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = S_FETCH;
            retire_c   = 1'b1;
         end
         S_MEM_WRITE: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (mem_ready) begin
               state_d  = S_FETCH;
               retire_c = 1'b1;
            end
         end
         S_R_EXEC: begin
            alu_src_a = 1'b1;
            state_d   = S_R_WB;
            case (funct)
               FN_ADD:  alu_ctrl = ALU_ADD;
               FN_SUB:  alu_ctrl = ALU_SUB;
               FN_AND:  alu_ctrl = ALU_AND;
               FN_OR:   alu_ctrl = ALU_OR;
               FN_SLT:  alu_ctrl = ALU_SLT;
               default: begin
                  // Unknown funct aborts without a register write.
                  alu_ctrl  = ALU_ADD;
                  state_d   = S_FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = S_FETCH;
            retire_c  = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_ctrl      = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            state_d       = S_FETCH;
            retire_c      = 1'b1;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            state_d   = S_FETCH;
            retire_c  = 1'b1;
         end
         S_ADDI_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_ctrl  = ALU_ADD;
            state_d   = S_ADDI_WB;
         end
         S_ADDI_WB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
            retire_c  = 1'b1;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase

      // Strobes must be quiet during reset even though state clears on the edge.
      if (rst) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         ir_write      = 1'b0;
         reg_write     = 1'b0;
      end
   end

   assign retired_d = retired_q + CNT_W'(retire_c);

   assign state   = state_q;
   assign illegal = illegal_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
module tb_mips_multicycle_control;

   logic        clk;
   logic        rst;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero;
   logic        mem_ready;
   logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0]  alu_src_b, pc_source;
   logic [2:0]  alu_ctrl;
   logic [3:0]  state;
   logic        illegal;
   logic [31:0] retired;

   // Narrow-counter instance for the wrap check; runs jumps only.
   logic        rst4;
   logic [5:0]  opcode4;
   logic        pw4, pwc4, iod4, mr4, mw4, irw4, m2r4, rd4, rw4, asa4;
   logic [1:0]  asb4, pcs4;
   logic [2:0]  alu4;
   logic [3:0]  state4;
   logic        illegal4;
   logic [3:0]  retired4;

   int checks;
   int failures;
   int exp_retired;

   logic [13:0] obs_ctrl;
   assign obs_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source};

   mips_multicycle_control #(.CNT_W(32)) u_dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_ctrl(alu_ctrl), .pc_source(pc_source), .state(state),
      .illegal(illegal), .retired(retired)
   );

   mips_multicycle_control #(.CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst4), .opcode(opcode4), .funct(6'h20), .zero(1'b0),
      .mem_ready(1'b1), .pc_write(pw4), .pc_write_cond(pwc4),
      .i_or_d(iod4), .mem_read(mr4), .mem_write(mw4),
      .ir_write(irw4), .mem_to_reg(m2r4), .reg_dst(rd4),
      .reg_write(rw4), .alu_src_a(asa4), .alu_src_b(asb4),
      .alu_ctrl(alu4), .pc_source(pcs4), .state(state4),
      .illegal(illegal4), .retired(retired4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {pw,pwc,iod,mr,mw,irw,m2r,rd,rw,asa,asb,pcs} with mem_ready=1.
   function automatic logic [13:0] exp_ctrl(input logic [3:0] s);
      case (s)
         4'd0:    return 14'b1001010000_01_00;
         4'd1:    return 14'b0000000000_11_00;
         4'd2:    return 14'b0000000001_10_00;
         4'd3:    return 14'b0011000000_00_00;
         4'd4:    return 14'b0000001010_00_00;
         4'd5:    return 14'b0010100000_00_00;
         4'd6:    return 14'b0000000001_00_00;
         4'd7:    return 14'b0000000110_00_00;
         4'd8:    return 14'b0100000001_00_01;
         4'd9:    return 14'b1000000000_00_10;
         4'd10:   return 14'b0000000001_10_00;
         4'd11:   return 14'b0000000010_00_00;
         default: return 14'b0;
      endcase
   endfunction

   function automatic logic [2:0] exp_alu(input logic [3:0] s, input logic [5:0] fn);
      case (s)
         4'd0, 4'd1, 4'd2, 4'd10: return 3'b010;
         4'd8:                    return 3'b110;
         4'd6: begin
            case (fn)
               6'h22:   return 3'b110;
               6'h24:   return 3'b000;
               6'h25:   return 3'b001;
               6'h2A:   return 3'b111;
               default: return 3'b010;
            endcase
         end
         default: return 3'b000;
      endcase
   endfunction

   task automatic test_reset();
      rst = 1'b1; mem_ready = 1'b1; opcode = 6'h00; funct = 6'h20;
      #1;
      checks++;
      if ({pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write} !== 6'b0) begin
         failures++;
         $display("FAIL reset_strobes_t0 got=%b want=000000",
                  {pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write});
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         checks++;
         if (state !== 4'd0 || retired !== 32'd0 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_state cyc=%0d got state=%0d retired=%0d illegal=%b want 0/0/0",
                     i, state, retired, illegal);
         end
         checks++;
         if ({pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write} !== 6'b0) begin
            failures++;
            $display("FAIL reset_strobes cyc=%0d got=%b want=000000", i,
                     {pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write});
         end
      end
      rst = 1'b0;
      #1;
      checks++;
      if (state !== 4'd0 || ir_write !== 1'b1 || pc_write !== 1'b1 || mem_read !== 1'b1) begin
         failures++;
         $display("FAIL first_fetch got state=%0d ir_write=%b pc_write=%b mem_read=%b want 0/1/1/1",
                  state, ir_write, pc_write, mem_read);
      end
      exp_retired = 0;
   endtask

   task automatic test_sequence();
      logic [5:0] ops [6]  = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
      int         lens [6] = '{4, 5, 4, 3, 3, 4};
      int         path [6][5] = '{'{0, 1, 6, 7, 0}, '{0, 1, 2, 3, 4}, '{0, 1, 2, 5, 0},
                                  '{0, 1, 8, 0, 0}, '{0, 1, 9, 0, 0}, '{0, 1, 10, 11, 0}};
      int cycles = 0;
      for (int i = 0; i < 6; i++) begin
         for (int c = 0; c < lens[i]; c++) begin
            opcode = ops[i]; funct = 6'h20; mem_ready = 1'b1;
            #1;
            checks++;
            if (state !== 4'(path[i][c])) begin
               failures++;
               $display("FAIL seq_state ins=%0d cyc=%0d got=%0d want=%0d", i, c, state, path[i][c]);
            end
            checks++;
            if (obs_ctrl !== exp_ctrl(4'(path[i][c]))) begin
               failures++;
               $display("FAIL seq_ctrl ins=%0d cyc=%0d got=%b want=%b", i, c, obs_ctrl,
                        exp_ctrl(4'(path[i][c])));
            end
            checks++;
            if (alu_ctrl !== exp_alu(4'(path[i][c]), 6'h20)) begin
               failures++;
               $display("FAIL seq_alu ins=%0d cyc=%0d got=%b want=%b", i, c, alu_ctrl,
                        exp_alu(4'(path[i][c]), 6'h20));
            end
            @(negedge clk);
            cycles++;
         end
      end
      exp_retired += 6;
      #1;
      checks++;
      if (cycles != 23 || retired !== 32'(exp_retired) || state !== 4'd0) begin
         failures++;
         $display("FAIL seq_retired got retired=%0d state=%0d cycles=%0d want %0d/0/23",
                  retired, state, cycles, exp_retired);
      end
   endtask

   task automatic test_alu_funct();
      logic [5:0] fns [4] = '{6'h22, 6'h24, 6'h25, 6'h2A};
      int         st  [4] = '{0, 1, 6, 7};
      for (int i = 0; i < 4; i++) begin
         for (int c = 0; c < 4; c++) begin
            opcode = 6'h00; funct = fns[i]; mem_ready = 1'b1;
            #1;
            checks++;
            if (state !== 4'(st[c]) || alu_ctrl !== exp_alu(4'(st[c]), fns[i])) begin
               failures++;
               $display("FAIL funct_alu fn=%h cyc=%0d got state=%0d alu=%b want %0d/%b", fns[i], c,
                        state, alu_ctrl, st[c], exp_alu(4'(st[c]), fns[i]));
            end
            @(negedge clk);
         end
      end
      exp_retired += 4;
      #1;
      checks++;
      if (retired !== 32'(exp_retired)) begin
         failures++;
         $display("FAIL funct_retired got=%0d want=%0d", retired, exp_retired);
      end
   endtask

   task automatic test_stall();
      logic [5:0] ops [15] = '{6'h23, 6'h23, 6'h23, 6'h23, 6'h23, 6'h23, 6'h23, 6'h23, 6'h23,
                               6'h23, 6'h2B, 6'h2B, 6'h2B, 6'h2B, 6'h2B};
      logic       rdy [15] = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 0, 1};
      int         st  [15] = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 4, 0, 1, 2, 5, 5};
      logic [13:0] e;
      for (int c = 0; c < 15; c++) begin
         opcode = ops[c]; funct = 6'h20; mem_ready = rdy[c];
         #1;
         e = exp_ctrl(4'(st[c]));
         if (st[c] == 0 && !rdy[c]) begin
            e[13] = 1'b0;
            e[8]  = 1'b0;
         end
         checks++;
         if (state !== 4'(st[c]) || obs_ctrl !== e) begin
            failures++;
            $display("FAIL stall cyc=%0d got state=%0d ctrl=%b want %0d/%b", c, state, obs_ctrl,
                     st[c], e);
         end
         @(negedge clk);
      end
      mem_ready = 1'b1;
      exp_retired += 2;
      #1;
      checks++;
      if (state !== 4'd0 || retired !== 32'(exp_retired)) begin
         failures++;
         $display("FAIL stall_retired got state=%0d retired=%0d want 0/%0d", state, retired,
                  exp_retired);
      end
   endtask

   task automatic test_illegal();
      logic [5:0] ops [9] = '{6'h3F, 6'h3F, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
      logic [5:0] fns [9] = '{6'h20, 6'h20, 6'h20, 6'h20, 6'h20, 6'h20, 6'h00, 6'h00, 6'h00};
      int         st  [9] = '{0, 1, 0, 1, 6, 7, 0, 1, 6};
      logic       ill [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 1};
      for (int c = 0; c < 9; c++) begin
         opcode = ops[c]; funct = fns[c]; mem_ready = 1'b1;
         #1;
         checks++;
         if (state !== 4'(st[c]) || illegal !== ill[c]) begin
            failures++;
            $display("FAIL illegal cyc=%0d got state=%0d illegal=%b want %0d/%b", c, state,
                     illegal, st[c], ill[c]);
         end
         if (c == 8) begin
            checks++;
            if (reg_write !== 1'b0) begin
               failures++;
               $display("FAIL illegal_funct_write got reg_write=%b want 0", reg_write);
            end
         end
         @(negedge clk);
      end
      exp_retired += 1;
      #1;
      checks++;
      if (state !== 4'd0 || illegal !== 1'b1 || retired !== 32'(exp_retired)) begin
         failures++;
         $display("FAIL illegal_end got state=%0d illegal=%b retired=%0d want 0/1/%0d", state,
                  illegal, retired, exp_retired);
      end
   endtask

   task automatic test_reset_mid();
      int   st  [4] = '{0, 1, 2, 3};
      logic rdy [4] = '{1, 1, 1, 0};
      for (int c = 0; c < 4; c++) begin
         opcode = 6'h23; funct = 6'h20; mem_ready = rdy[c];
         #1;
         checks++;
         if (state !== 4'(st[c])) begin
            failures++;
            $display("FAIL rmid_state cyc=%0d got=%0d want=%0d", c, state, st[c]);
         end
         if (c < 3) @(negedge clk);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (state !== 4'd3 || mem_read !== 1'b0) begin
         failures++;
         $display("FAIL rmid_strobe got state=%0d mem_read=%b want 3/0", state, mem_read);
      end
      @(negedge clk); #1;
      checks++;
      if (state !== 4'd0 || retired !== 32'd0 || illegal !== 1'b0) begin
         failures++;
         $display("FAIL rmid_clear got state=%0d retired=%0d illegal=%b want 0/0/0", state,
                  retired, illegal);
      end
      rst = 1'b0;
      mem_ready = 1'b1;
      exp_retired = 0;
      @(negedge clk);
   endtask

   task automatic test_wrap();
      rst4 = 1'b0;
      for (int c = 0; c < 45; c++) @(negedge clk);
      #1;
      checks++;
      if (retired4 !== 4'd15 || state4 !== 4'd0) begin
         failures++;
         $display("FAIL wrap_15 got retired=%0d state=%0d want 15/0", retired4, state4);
      end
      for (int c = 0; c < 3; c++) @(negedge clk);
      #1;
      checks++;
      if (retired4 !== 4'd0 || state4 !== 4'd0) begin
         failures++;
         $display("FAIL wrap_0 got retired=%0d state=%0d want 0/0", retired4, state4);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      exp_retired = 0;
      zero = 1'b0;
      rst4 = 1'b1;
      opcode4 = 6'h02;
      test_reset();
      test_sequence();
      test_alu_funct();
      test_stall();
      test_illegal();
      test_reset_mid();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
